// File: rtl/sram_bank_arbiter.sv
// sram_bank_arbiter: two-requester arbiter in front of N_SRAM banks of
// 32-bit synchronous SRAM. Each command goes through one ACCESS cycle, and
// reads add one RDRESP cycle in which the bank data is returned.
// Optional feature: define SRAM_ARB_ROUND_ROBIN_EN to make requesters take
// turns under contention. Without it, requester 0 has fixed priority.
module sram_bank_arbiter #(
    parameter int N_SRAM         = 2,
    parameter int SRAM_DEPTH     = 1024,
    parameter int INVERT_CE_EN   = 0,
    parameter int INVERT_BYTE_EN = 0
) (
    input  logic                   HCLK,
    input  logic                   HRESETn,
    input  logic                   req0,
    input  logic                   req1,
    input  logic                   wen0,
    input  logic                   wen1,
    input  logic [31:0]            addr0,
    input  logic [31:0]            addr1,
    input  logic [31:0]            wdata0,
    input  logic [31:0]            wdata1,
    input  logic [3:0]             be0,
    input  logic [3:0]             be1,
    output logic                   gnt0,
    output logic                   gnt1,
    output logic                   rvalid0,
    output logic                   rvalid1,
    output logic [31:0]            rdata0,
    output logic [31:0]            rdata1,
    output logic                   err0,
    output logic                   err1,
    output logic                   busy,
    output logic [N_SRAM-1:0]      sram_en,
    output logic                   wen,
    output logic [31:0]            ram_addr,
    output logic [31:0]            ram_wData,
    output logic [3:0]             byte_en,
    input  logic [N_SRAM-1:0][31:0] ram_rData
);

    localparam int AW = (SRAM_DEPTH > 1) ? $clog2(SRAM_DEPTH) : 1;
    localparam int BW = (N_SRAM > 1) ? $clog2(N_SRAM) : 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RDRESP = 2'd2
    } state_t;

    state_t state;

    // Registered command, captured on grant
    logic              cmd_wen;
    logic              cmd_owner;
    logic              cmd_oor;
    logic [BW-1:0]     cmd_bank;

    // Registered SRAM-side and response outputs (active-high internally)
    logic [N_SRAM-1:0] en_q;
    logic [3:0]        be_q;
    logic              wen_q;
    logic [31:0]       ram_addr_q;
    logic [31:0]       wdata_q;
    logic              rvalid0_q;
    logic              rvalid1_q;
    logic              err0_q;
    logic              err1_q;

    logic              can_grant;
    logic              grant0;
    logic              grant1;

    // Selected command from whichever requester wins this cycle
    logic              sel_wen;
    logic [31:0]       sel_addr;
    logic [31:0]       sel_wdata;
    logic [3:0]        sel_be;
    logic [31:0]       sel_upper;
    logic              sel_oor;
    logic [BW-1:0]     sel_bank;
    logic [AW-1:0]     sel_word;
    logic [N_SRAM-1:0] sel_en;
    logic [31:0]       resp_data;

`ifdef SRAM_ARB_ROUND_ROBIN_EN
    logic              rr_last;
`endif

    assign can_grant = HRESETn && ((state == IDLE) || (state == RDRESP));

`ifdef SRAM_ARB_ROUND_ROBIN_EN
    // Under contention, grant the requester that was not granted most recently
    always_comb begin
        grant0 = can_grant && req0 && (!req1 || rr_last);
        grant1 = can_grant && req1 && (!req0 || !rr_last);
    end
`else
    // Fixed priority: requester 0 always wins contention
    always_comb begin
        grant0 = can_grant && req0;
        grant1 = can_grant && req1 && !req0;
    end
`endif

    // Mux the winning command and decode its bank, word index and range check
    always_comb begin
        sel_wen   = grant1 ? wen1   : wen0;
        sel_addr  = grant1 ? addr1  : addr0;
        sel_wdata = grant1 ? wdata1 : wdata0;
        sel_be    = grant1 ? be1    : be0;
        sel_word  = sel_addr[2 +: AW];
        sel_bank  = sel_addr[2 + AW +: BW];
        sel_upper = sel_addr >> (2 + AW);
        sel_oor   = (sel_upper >= 32'(N_SRAM));
        sel_en    = '0;
        for (int b = 0; b < N_SRAM; b++) begin
            if (!sel_oor && (sel_bank == BW'(b))) begin
                sel_en[b] = 1'b1;
            end
        end
    end

    // FSM plus every registered output; strobes default low each cycle
    always_ff @(posedge HCLK) begin
        if (!HRESETn) begin
            state      <= IDLE;
            cmd_wen    <= 1'b0;
            cmd_owner  <= 1'b0;
            cmd_oor    <= 1'b0;
            cmd_bank   <= '0;
            en_q       <= '0;
            be_q       <= '0;
            wen_q      <= 1'b0;
            ram_addr_q <= '0;
            wdata_q    <= '0;
            rvalid0_q  <= 1'b0;
            rvalid1_q  <= 1'b0;
            err0_q     <= 1'b0;
            err1_q     <= 1'b0;
`ifdef SRAM_ARB_ROUND_ROBIN_EN
            rr_last    <= 1'b1;
`endif
        end else begin
            en_q      <= '0;
            be_q      <= '0;
            wen_q     <= 1'b0;
            rvalid0_q <= 1'b0;
            rvalid1_q <= 1'b0;
            err0_q    <= 1'b0;
            err1_q    <= 1'b0;

            case (state)
                IDLE: begin
                    if (grant0 || grant1) begin
                        state <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (cmd_wen) begin
                        state <= IDLE;
                    end else begin
                        state     <= RDRESP;
                        rvalid0_q <= !cmd_owner;
                        rvalid1_q <= cmd_owner;
                    end
                end
                RDRESP: begin
                    if (grant0 || grant1) begin
                        state <= ACCESS;
                    end else begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase

            if (grant0 || grant1) begin
                cmd_wen    <= sel_wen;
                cmd_owner  <= grant1;
                cmd_oor    <= sel_oor;
                cmd_bank   <= sel_bank;
                en_q       <= sel_en;
                be_q       <= sel_be;
                wen_q      <= sel_wen && !sel_oor;
                ram_addr_q <= 32'(sel_word);
                wdata_q    <= sel_wdata;
                err0_q     <= grant0 && sel_oor;
                err1_q     <= grant1 && sel_oor;
`ifdef SRAM_ARB_ROUND_ROBIN_EN
                rr_last    <= grant1;
`endif
            end
        end
    end

    // Out-of-range reads return a recognisable poison word instead of bank data
    assign resp_data = cmd_oor ? 32'hBAD1BAD1 : ram_rData[cmd_bank];

    assign gnt0      = grant0;
    assign gnt1      = grant1;
    assign rvalid0   = rvalid0_q;
    assign rvalid1   = rvalid1_q;
    assign rdata0    = rvalid0_q ? resp_data : 32'h0;
    assign rdata1    = rvalid1_q ? resp_data : 32'h0;
    assign err0      = err0_q;
    assign err1      = err1_q;
    assign busy      = (state != IDLE);
    assign sram_en   = (INVERT_CE_EN != 0) ? ~en_q : en_q;
    assign byte_en   = (INVERT_BYTE_EN != 0) ? ~be_q : be_q;
    assign wen       = wen_q;
    assign ram_addr  = ram_addr_q;
    assign ram_wData = wdata_q;

endmodule

// File: tb/tb_sram_bank_arbiter.sv
// tb_sram_bank_arbiter: cycle-table checks of sram_bank_arbiter with a small
// behavioural SRAM model, plus hand-written reset-abort and contention runs.
// A second instance with inverted enables checks the polarity parameters.
module tb_sram_bank_arbiter;

    logic              HCLK = 1'b0;
    logic              HRESETn;
    logic              req0, req1, wen0, wen1;
    logic [31:0]       addr0, addr1, wdata0, wdata1;
    logic [3:0]        be0, be1;
    logic              gnt0, gnt1, rvalid0, rvalid1, err0, err1, busy, wen;
    logic [31:0]       rdata0, rdata1, ram_addr, ram_wData;
    logic [1:0]        sram_en;
    logic [3:0]        byte_en;
    logic [1:0][31:0]  ram_rData;

    logic              i_gnt0, i_gnt1, i_rvalid0, i_rvalid1, i_err0, i_err1, i_busy, i_wen;
    logic [31:0]       i_rdata0, i_rdata1, i_ram_addr, i_ram_wData;
    logic [1:0]        i_sram_en;
    logic [3:0]        i_byte_en;

    logic [31:0]       mem [2][16];

    int                n_checks = 0;
    int                n_fail   = 0;

    always #5 HCLK = ~HCLK;

    sram_bank_arbiter #(.N_SRAM(2), .SRAM_DEPTH(1024), .INVERT_CE_EN(0), .INVERT_BYTE_EN(0)) dut (
        .HCLK(HCLK), .HRESETn(HRESETn),
        .req0(req0), .req1(req1), .wen0(wen0), .wen1(wen1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .be0(be0), .be1(be1),
        .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
        .rdata0(rdata0), .rdata1(rdata1), .err0(err0), .err1(err1), .busy(busy),
        .sram_en(sram_en), .wen(wen), .ram_addr(ram_addr), .ram_wData(ram_wData),
        .byte_en(byte_en), .ram_rData(ram_rData)
    );

    sram_bank_arbiter #(.N_SRAM(2), .SRAM_DEPTH(1024), .INVERT_CE_EN(1), .INVERT_BYTE_EN(1)) dut_inv (
        .HCLK(HCLK), .HRESETn(HRESETn),
        .req0(req0), .req1(req1), .wen0(wen0), .wen1(wen1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .be0(be0), .be1(be1),
        .gnt0(i_gnt0), .gnt1(i_gnt1), .rvalid0(i_rvalid0), .rvalid1(i_rvalid1),
        .rdata0(i_rdata0), .rdata1(i_rdata1), .err0(i_err0), .err1(i_err1), .busy(i_busy),
        .sram_en(i_sram_en), .wen(i_wen), .ram_addr(i_ram_addr), .ram_wData(i_ram_wData),
        .byte_en(i_byte_en), .ram_rData(ram_rData)
    );

    // Behavioural SRAM banks: byte-masked writes, registered read data
    always @(posedge HCLK) begin
        if (!HRESETn) begin
            for (int b = 0; b < 2; b++) begin
                for (int w = 0; w < 16; w++) begin
                    mem[b][w] <= 32'h0;
                end
            end
            ram_rData <= '0;
        end else begin
            for (int b = 0; b < 2; b++) begin
                if (sram_en[b]) begin
                    if (wen) begin
                        for (int k = 0; k < 4; k++) begin
                            if (byte_en[k]) mem[b][ram_addr[3:0]][k*8 +: 8] <= ram_wData[k*8 +: 8];
                        end
                    end
                    ram_rData[b] <= mem[b][ram_addr[3:0]];
                end
            end
        end
    end

    typedef struct {
        logic        req;
        logic        wen;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
    } cmd_t;

    typedef struct {
        logic [1:0]  gnt;
        logic [1:0]  rvalid;
        logic [31:0] rd0;
        logic [31:0] rd1;
        logic [1:0]  err;
        logic        busy;
        logic [1:0]  sram_en;
        logic        wen;
        logic [31:0] ram_addr;
        logic [3:0]  byte_en;
    } exp_t;

    typedef struct {
        cmd_t c0;
        cmd_t c1;
        exp_t e;
    } vec_t;

    function automatic cmd_t c(input logic r, input logic w, input logic [31:0] a,
                               input logic [31:0] d, input logic [3:0] b);
        cmd_t x;
        x.req = r; x.wen = w; x.addr = a; x.wdata = d; x.be = b;
        return x;
    endfunction

    function automatic exp_t e(input logic [1:0] g, input logic [1:0] rv, input logic [31:0] r0,
                               input logic [31:0] r1, input logic [1:0] er, input logic bz,
                               input logic [1:0] en, input logic w, input logic [31:0] ad,
                               input logic [3:0] be);
        exp_t x;
        x.gnt = g; x.rvalid = rv; x.rd0 = r0; x.rd1 = r1; x.err = er; x.busy = bz;
        x.sram_en = en; x.wen = w; x.ram_addr = ad; x.byte_en = be;
        return x;
    endfunction

    task automatic applyStimulus(input cmd_t a, input cmd_t b);
        req0 = a.req; wen0 = a.wen; addr0 = a.addr; wdata0 = a.wdata; be0 = a.be;
        req1 = b.req; wen1 = b.wen; addr1 = b.addr; wdata1 = b.wdata; be1 = b.be;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic checkRow(input string tag, input exp_t x);
        checkOutput({tag, " gnt"},      {30'h0, gnt1, gnt0},       {30'h0, x.gnt});
        checkOutput({tag, " rvalid"},   {30'h0, rvalid1, rvalid0}, {30'h0, x.rvalid});
        checkOutput({tag, " rdata0"},   rdata0,                    x.rd0);
        checkOutput({tag, " rdata1"},   rdata1,                    x.rd1);
        checkOutput({tag, " err"},      {30'h0, err1, err0},       {30'h0, x.err});
        checkOutput({tag, " busy"},     {31'h0, busy},             {31'h0, x.busy});
        checkOutput({tag, " sram_en"},  {30'h0, sram_en},          {30'h0, x.sram_en});
        checkOutput({tag, " wen"},      {31'h0, wen},              {31'h0, x.wen});
        checkOutput({tag, " ram_addr"}, ram_addr,                  x.ram_addr);
        checkOutput({tag, " byte_en"},  {28'h0, byte_en},          {28'h0, x.byte_en});
        checkOutput({tag, " inv sram_en"}, {30'h0, i_sram_en},     {30'h0, ~x.sram_en});
        checkOutput({tag, " inv byte_en"}, {28'h0, i_byte_en},     {28'h0, ~x.byte_en});
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, " gnt"},       {30'h0, gnt1, gnt0},       32'h0);
        checkOutput({tag, " rvalid"},    {30'h0, rvalid1, rvalid0}, 32'h0);
        checkOutput({tag, " err"},       {30'h0, err1, err0},       32'h0);
        checkOutput({tag, " busy"},      {31'h0, busy},             32'h0);
        checkOutput({tag, " sram_en"},   {30'h0, sram_en},          32'h0);
        checkOutput({tag, " wen"},       {31'h0, wen},              32'h0);
        checkOutput({tag, " ram_addr"},  ram_addr,                  32'h0);
        checkOutput({tag, " ram_wData"}, ram_wData,                 32'h0);
        checkOutput({tag, " byte_en"},   {28'h0, byte_en},          32'h0);
        checkOutput({tag, " inv sram_en"}, {30'h0, i_sram_en},      32'h3);
        checkOutput({tag, " inv byte_en"}, {28'h0, i_byte_en},      32'hF);
    endtask

    vec_t tbl [18];
    cmd_t idle_c;

    initial begin
        idle_c = c(0, 0, 32'h0, 32'h0, 4'h0);

        // Each row is one clock cycle: inputs driven and outputs expected in that cycle
        tbl[0]  = '{c(1,1,32'h10,32'hDEADBEEF,4'hF), idle_c, e(2'b01,2'b00,0,0,2'b00,0,2'b00,0,0,4'h0)};
        tbl[1]  = '{idle_c, idle_c,                  e(2'b00,2'b00,0,0,2'b00,1,2'b01,1,4,4'hF)};
        tbl[2]  = '{c(1,0,32'h10,32'h0,4'hF), idle_c, e(2'b01,2'b00,0,0,2'b00,0,2'b00,0,4,4'h0)};
        tbl[3]  = '{idle_c, idle_c,                  e(2'b00,2'b00,0,0,2'b00,1,2'b01,0,4,4'hF)};
        tbl[4]  = '{idle_c, idle_c,                  e(2'b00,2'b01,32'hDEADBEEF,0,2'b00,1,2'b00,0,4,4'h0)};
        tbl[5]  = '{c(1,1,32'h1008,32'h11223344,4'h3), idle_c, e(2'b01,2'b00,0,0,2'b00,0,2'b00,0,4,4'h0)};
        tbl[6]  = '{idle_c, idle_c,                  e(2'b00,2'b00,0,0,2'b00,1,2'b10,1,2,4'h3)};
        tbl[7]  = '{idle_c, c(1,0,32'h1008,32'h0,4'hF), e(2'b10,2'b00,0,0,2'b00,0,2'b00,0,2,4'h0)};
        tbl[8]  = '{idle_c, idle_c,                  e(2'b00,2'b00,0,0,2'b00,1,2'b10,0,2,4'hF)};
        tbl[9]  = '{idle_c, c(1,0,32'h10,32'h0,4'hF), e(2'b10,2'b10,0,32'h00003344,2'b00,1,2'b00,0,2,4'h0)};
        tbl[10] = '{idle_c, idle_c,                  e(2'b00,2'b00,0,0,2'b00,1,2'b01,0,4,4'hF)};
        tbl[11] = '{c(1,0,32'h2000,32'h0,4'hF), idle_c, e(2'b01,2'b10,0,32'hDEADBEEF,2'b00,1,2'b00,0,4,4'h0)};
        tbl[12] = '{idle_c, c(1,1,32'h14,32'hCAFEF00D,4'hF), e(2'b00,2'b00,0,0,2'b01,1,2'b00,0,0,4'hF)};
        tbl[13] = '{idle_c, idle_c,                  e(2'b00,2'b01,32'hBAD1BAD1,0,2'b00,1,2'b00,0,0,4'h0)};
        tbl[14] = '{idle_c, idle_c,                  e(2'b00,2'b00,0,0,2'b00,0,2'b00,0,0,4'h0)};
        tbl[15] = '{c(1,0,32'h14,32'h0,4'hF), idle_c, e(2'b01,2'b00,0,0,2'b00,0,2'b00,0,0,4'h0)};
        tbl[16] = '{idle_c, idle_c,                  e(2'b00,2'b00,0,0,2'b00,1,2'b01,0,5,4'hF)};
        tbl[17] = '{idle_c, idle_c,                  e(2'b00,2'b01,0,0,2'b00,1,2'b00,0,5,4'h0)};

        // Reset with a pending request: nothing may be granted while reset is low
        HRESETn = 1'b0;
        applyStimulus(c(1,1,32'h10,32'h12345678,4'hF), idle_c);
        repeat (2) @(negedge HCLK);
        #1;
        checkResetValues("reset");
        applyStimulus(idle_c, idle_c);
        HRESETn = 1'b1;

        for (int i = 0; i < 18; i++) begin
            @(negedge HCLK);
            applyStimulus(tbl[i].c0, tbl[i].c1);
            #1;
            checkRow($sformatf("row%0d", i), tbl[i].e);
        end

        // Reset asserted during the ACCESS cycle of a read aborts it
        @(negedge HCLK);
        applyStimulus(c(1,0,32'h10,32'h0,4'hF), idle_c);
        #1;
        checkOutput("abort gnt0", {31'h0, gnt0}, 32'h1);
        @(negedge HCLK);
        applyStimulus(idle_c, idle_c);
        #1;
        checkOutput("abort access sram_en", {30'h0, sram_en}, 32'h1);
        HRESETn = 1'b0;
        applyStimulus(c(1,0,32'h10,32'h0,4'hF), idle_c);
        @(negedge HCLK);
        #1;
        checkResetValues("abort reset");
        applyStimulus(idle_c, idle_c);
        HRESETn = 1'b1;
        @(negedge HCLK);
        #1;
        checkOutput("abort late rvalid", {30'h0, rvalid1, rvalid0}, 32'h0);
        checkOutput("abort busy", {31'h0, busy}, 32'h0);

        // Both requesters hold write requests for 8 cycles
        for (int k = 0; k < 8; k++) begin
            logic [1:0] exp_g;
            @(negedge HCLK);
            applyStimulus(c(1,1,32'h20,32'hA0A0A0A0,4'hF), c(1,1,32'h24,32'hB1B1B1B1,4'hF));
            #1;
            exp_g = 2'b00;
            if ((k % 2) == 0) begin
`ifdef SRAM_ARB_ROUND_ROBIN_EN
                exp_g = (((k / 2) % 2) == 0) ? 2'b01 : 2'b10;
`else
                exp_g = 2'b01;
`endif
            end
            checkOutput($sformatf("contend cycle%0d gnt", k), {30'h0, gnt1, gnt0}, {30'h0, exp_g});
        end
        @(negedge HCLK);
        applyStimulus(idle_c, idle_c);
        repeat (2) @(negedge HCLK);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/sram_bank_arbiter.md
SRAM_BANK_ARBITER -- requirements
Module: sram_bank_arbiter

Interface
REQ-001 Param N_SRAM, default 2: number of SRAM banks.
REQ-002 Param SRAM_DEPTH, default 1024: 32-bit words per bank.
REQ-003 Param INVERT_CE_EN, default 0: 1 makes sram_en active-low.
REQ-004 Param INVERT_BYTE_EN, default 0: 1 makes byte_en active-low.
REQ-005 Ports, as name, direction, width, meaning:
- HCLK  in  1  sole clock, all state on rising edge.
- HRESETn  in  1  reset, synchronous, active-low.
- req0 / req1  in  1  access request from requester 0 (bus side) / 1 (loader/DMA).
- wen0 / wen1  in  1  1 = write, 0 = read.
- addr0 / addr1  in  32  byte address.
- wdata0 / wdata1  in  32  write data.
- be0 / be1  in  4  byte lanes, active-high.
- gnt0 / gnt1  out  1  command accepted this cycle.
- rvalid0 / rvalid1  out  1  read data valid.
- rdata0 / rdata1  out  32  read data.
- err0 / err1  out  1  out-of-range access pulse.
- busy  out  1  high whenever state is not IDLE.
- sram_en  out  N_SRAM  per-bank chip enable.
- wen  out  1  SRAM write enable.
- ram_addr  out  32  word index within bank.
- ram_wData  out  32  SRAM write data.
- byte_en  out  4  SRAM byte lanes.
- ram_rData  in  N_SRAM x 32  per-bank read data, valid 1 cycle after enable.

Function
REQ-006 Bank index = addr[2+log2(SRAM_DEPTH) +: log2(N_SRAM)]; ram_addr = addr[2 +: log2(SRAM_DEPTH)], zero-extended; addr[1:0] ignored.
REQ-007 FSM states IDLE, ACCESS, RDRESP.
REQ-008 Grants issue only in IDLE or RDRESP; gnt_i is combinational, high in the cycle req_i is accepted; at most one gnt per cycle.
REQ-009 On grant, command registered; next cycle state = ACCESS, SRAM outputs driven from registers, sram_en active for the selected bank only.
REQ-010 ACCESS with write -> IDLE; ACCESS with read -> RDRESP.
REQ-011 RDRESP: rvalid_i of owning requester high for 1 cycle, rdata_i = ram_rData[bank]; another grant may issue same cycle (-> ACCESS), else -> IDLE.
REQ-012 Latency: read grant at T -> rvalid at T+2; peak throughput one access per 2 cycles.
REQ-013 Bank index >= N_SRAM: no sram_en asserted, write discarded, read returns 32'hBAD1BAD1 at T+2, err_i pulses at T+1.
REQ-014 Outside ACCESS: sram_en, byte_en inactive (polarity per params), wen=0, ram_addr/ram_wData hold last value.
REQ-015 rdata_i = 0 when rvalid_i low.
REQ-016 req_i is level; a requester holds req and command stable until gnt_i; dropping req before grant cancels with no side effect.

Reset
REQ-017 HRESETn low at a rising edge: state = IDLE, all gnt/rvalid/err = 0, busy = 0, wen = 0, ram_addr = 0, ram_wData = 0, sram_en and byte_en inactive, RR pointer = 1.
REQ-018 Reset mid-access aborts: no rvalid issued for an in-flight read; no grant in the reset cycle.

Configuration
REQ-019 Macro SRAM_ARB_ROUND_ROBIN_EN defined: simultaneous requests go to the requester not granted last; pointer updates only on grant; first contention after reset goes to requester 0.
REQ-020 Macro absent: fixed priority, requester 0 always wins contention; pointer logic omitted.

Verification
REQ-021 Write req0 addr 0x0000_0010 data 0xDEADBEEF be 0xF, then read -> gnt0 at T, sram_en=2'b01, ram_addr=4, rvalid0 at T+2 with 0xDEADBEEF.
REQ-022 Write addr 0x0000_1008 (bank 1, word 2) be 0x3 -> sram_en=2'b10, ram_addr=2, byte_en=4'b0011 during ACCESS.
REQ-023 req0 and req1 both held for 8 cycles with ROUND_ROBIN_EN -> grants 0,1,0,1; without macro -> grants 0 only.
REQ-024 Read addr 0x0000_2000 with N_SRAM=2 -> no sram_en, err pulse T+1, rdata 0xBAD1BAD1 at T+2.
REQ-025 Back-to-back reads -> second gnt in RDRESP cycle of first; rvalid spacing 2 cycles.
REQ-026 HRESETn low in ACCESS of a read -> no rvalid, all outputs at reset values next cycle; INVERT_CE_EN=1 -> idle sram_en all ones.
